sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the UART byte buffer.
//  Configurable width/depth, simultaneous read+write, almost-full/empty thresholds,
//  fill level, sticky overflow/underflow. EDGE_MODE=1 keeps legacy edge-strobe interface.
//  Sits between UART RX/TX engines and the host-side logic.
// PARAMETERS
//  DATA_W    8    data word width, bits
//  ADDR_W    8    address width; DEPTH = 2**ADDR_W words
//  AF_LEVEL  240  almost_full asserts when level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  16   almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)
//  EDGE_MODE 0    0: wr_en/rd_en level-qualified per cycle; 1: one request per rising edge
// PORTS
//  sys_clk       in   1         clock, all logic on rising edge
//  rst_n         in   1         asynchronous reset, active low
//  clr           in   1         synchronous flush
//  wr_en         in   1         write request
//  data_in       in   DATA_W    write data
//  full          out  1         level == DEPTH
//  almost_full   out  1         level >= AF_LEVEL
//  rd_en         in   1         read request (pop)
//  data_out      out  DATA_W    head word, first-word-fall-through
//  empty         out  1         level == 0
//  almost_empty  out  1         level <= AE_LEVEL
//  level         out  ADDR_W+1  current word count, 0..DEPTH
//  overflow      out  1         sticky: write requested and rejected
//  underflow     out  1         sticky: read requested while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): rd/wr pointers=0, level=0, empty=1, almost_empty=1, full=0,
//    almost_full=0, overflow=0, underflow=0, edge detectors cleared. RAM not reset.
//    Reset mid-operation discards all contents immediately.
//  - Requests: EDGE_MODE=0: wr_req=wr_en, rd_req=rd_en each cycle.
//    EDGE_MODE=1: 2-flop sample per input; req = s0 & ~s1, one-cycle pulse the cycle after
//    the first sys_clk edge sampling the input high; data_in held stable >=2 cycles.
//  - Write accepted: wr_req & (~full | rd_req). Read accepted: rd_req & ~empty.
//  - Empty + both requested: write accepted, read rejected (underflow sets), level 0->1.
//  - Full + both requested: both accepted, level unchanged, overflow does not set.
//  - Write: mem[wr_ptr]<=data_in; wr_ptr++. Read: rd_ptr++. Pointers ADDR_W+1 bits, wrap
//    mod 2*DEPTH; RAM index = low ADDR_W bits.
//  - level: +1 write only, -1 read only, unchanged both/neither; registered.
//    All status flags decode from registered level: valid the cycle after the transfer.
//  - data_out = mem[rd_ptr[ADDR_W-1:0]] combinational; valid whenever empty=0; a pop
//    shows the next word after that clock edge. Don't-care while empty.
//  - overflow sets on wr_req & full & ~rd_req; underflow sets on rd_req & empty;
//    both hold until clr or reset.
//  - clr=1: pointers, level, overflow, underflow -> reset values next edge; clr overrides
//    wr/rd that cycle (no write stored). Edge detector flops unaffected.
//  - No state machine beyond pointers/level; latency write->data_out visible = 1 cycle.
// TESTING
//  1 Reset: rst_n low mid-burst -> level=0, empty=1, almost_empty=1, flags 0, same cycle.
//  2 Write 0x00..0xFF (DEPTH=256), one/cycle -> full=1 after 256th edge, level=256;
//    257th write -> rejected, overflow=1; read all -> 0x00..0xFF in order, empty=1.
//  3 Full, wr_en=rd_en=1 with 0xA5 -> head popped, 0xA5 at tail, level 256, no overflow.
//  4 Empty, wr_en=rd_en=1 with 0x3C -> level=1, underflow=1, data_out=0x3C next cycle.
//  5 AF_LEVEL=4, AE_LEVEL=1: fill 0..5 -> almost_empty drops at level 2, almost_full
//    rises at 4; clr -> level=0, overflow/underflow 0.
//  6 EDGE_MODE=1: wr_en held high 10 cycles with 0x55 -> exactly one write, level=1.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Host-facing bundle of the parametrised FIFO: push/pop strobes, data and status.
// The master side drives requests and flush; the slave side (the FIFO) drives status.
interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              clr;
   logic              wr_en;
   logic [DATA_W-1:0] data_in;
   logic              full;
   logic              almost_full;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              empty;
   logic              almost_empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              underflow;

   modport master (
      output clr, wr_en, data_in, rd_en,
      input  full, almost_full, data_out, empty, almost_empty, level, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, data_in, rd_en,
      output full, almost_full, data_out, empty, almost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO; write visible on data_out 1 cycle later.
// No backpressure stall: writes to a full FIFO are dropped (sticky overflow) unless a pop coincides.
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int AF_LEVEL  = 240,
   parameter int AE_LEVEL  = 16,
   parameter int EDGE_MODE = 0
) (
   input logic              sys_clk,
   input logic              rst_n,
   sync_fifo_param_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_L    = (ADDR_W + 1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   level_q;
   logic              ovf_q;
   logic              unf_q;
   logic              wr_req;
   logic              rd_req;
   logic              wr_acc;
   logic              rd_acc;
   logic              full_w;
   logic              empty_w;

   generate
      if (EDGE_MODE != 0) begin : g_edge
         logic wr_s0, wr_s1, rd_s0, rd_s1;

         // Edge detectors are deliberately left alone by clr.
         always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_s0 <= 1'b0;
               wr_s1 <= 1'b0;
               rd_s0 <= 1'b0;
               rd_s1 <= 1'b0;
            end else begin
               wr_s0 <= bus.wr_en;
               wr_s1 <= wr_s0;
               rd_s0 <= bus.rd_en;
               rd_s1 <= rd_s0;
            end
         end

         assign wr_req = wr_s0 & ~wr_s1;
         assign rd_req = rd_s0 & ~rd_s1;
      end else begin : g_level
         assign wr_req = bus.wr_en;
         assign rd_req = bus.rd_en;
      end
   endgenerate

   assign full_w  = (level_q == DEPTH_L);
   assign empty_w = (level_q == '0);

   // A pop frees the slot a simultaneous push needs, so full only blocks a lone write.
   assign wr_acc = wr_req & (~full_w | rd_req) & ~bus.clr;
   assign rd_acc = rd_req & ~empty_w & ~bus.clr;

   always_ff @(posedge sys_clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (bus.clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_acc && !rd_acc) begin
            level_q <= level_q + 1'b1;
         end else if (rd_acc && !wr_acc) begin
            level_q <= level_q - 1'b1;
         end
         if (wr_req && full_w && !rd_req) begin
            ovf_q <= 1'b1;
         end
         if (rd_req && empty_w) begin
            unf_q <= 1'b1;
         end
      end
   end

   assign bus.data_out     = mem[rd_ptr[ADDR_W-1:0]];
   assign bus.level        = level_q;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (level_q >= AF_L);
   assign bus.almost_empty = (level_q <= AE_L);
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule
